huc_bus_responder: RTL
======================

# huc_bus_responder

Target-side responder for the cpu_HuC6280 21-bit external bus: decodes each physical address presented on AB_21 and RE/WE, and services the access. Accesses are served from internal 8 KB work RAM, a handshaked ROM port, or a fixed-latency I/O port. RDY_n stalls the CPU for slow regions. It replaces the behavioural memory model as the system-level target and sits between the CPU core and the ROM/I/O fabric.

## Interface
- ROM_TIMEOUT, 255: max cycles rom_req may wait for rom_ack (8-bit counter).
- IO_WAIT, 1: wait cycles inserted for I/O-page accesses (1..15).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  CPU clock enable; FSM, counters and RAM writes advance only when high
- AB_21  in  21  physical address from CPU
- RE, WE  in  1 each  read / write strobe from CPU
- DO  in  8  write data from CPU
- DI  out  8  read data to CPU
- RDY_n  out  1  0 = ready, 1 = stall CPU
- rom_req  out  1  ROM read request, held until ack
- rom_addr  out  20  latched AB_21[19:0]
- rom_ack  in  1  one-cycle ack; rom_data valid the same cycle
- rom_data  in  8  ROM read data
- io_req  out  1  single-cycle I/O strobe
- io_we  out  1  I/O write qualifier
- io_addr  out  13  latched AB_21[12:0]
- io_wdata  out  8  latched DO
- io_rdata  in  8  I/O read data, sampled on the last wait cycle
- bus_err  out  1  sticky error flag, cleared only by reset

## Operation
- Decode by AB_21[20:13] (page):
  - $00-$7F: ROM, read-only.
  - $F8-$FB: WRAM, 8 KB at AB_21[12:0], mirrored 4x.
  - $FF: I/O.
  - Others: unmapped.
- FSM states: IDLE, ROM_WAIT, IO_WAIT, DONE. An access is accepted only in IDLE with clk_en=1 and RE|WE.
- WRAM write: written at the accept edge. No stall.
- WRAM read: DI registered from RAM; valid the cycle after accept. No stall.
- ROM read: latch rom_addr, go ROM_WAIT.
- ROM write: ignored, no stall, no error.
- I/O access: latch io_addr, io_wdata and io_we; pulse io_req one cycle; go IO_WAIT.
- Unmapped read: DI=8'hFF next cycle. Unmapped write: dropped. Neither stalls.
- ROM_WAIT: rom_req=1. On rom_ack, DI<=rom_data and go DONE. On timeout, DI<=8'hFF, set bus_err, go DONE.
- IO_WAIT: count IO_WAIT enabled cycles. On the last one, DI<=io_rdata (reads only) and go DONE.
- DONE: RDY_n=0. The next enabled edge returns to IDLE without decoding. This absorbs the CPU's held repeat of the same access.
- RE&WE together: treated as a write, and bus_err is set.

## Timing
- Reset values: state IDLE, DI=8'hFF, RDY_n=0, rom_req=0, io_req=0, io_we=0, rom_addr=0, io_addr=0, io_wdata=0, bus_err=0. WRAM contents are not reset.
- RDY_n is combinational:
  - 1 in the accept cycle for ROM-read or I/O decodes, so the CPU does not advance.
  - 1 throughout ROM_WAIT and IO_WAIT.
  - 0 otherwise.
- ROM read: rom_req rises at the edge after accept. For rom_ack in cycle M, DI is valid and RDY_n=0 from M+1.
- rom_ack outside ROM_WAIT: ignored.
- I/O: io_req is high exactly one cycle, starting the edge after accept. DONE is entered IO_WAIT enabled cycles after that.
- clk_en=0: all state, counters and DI hold. rom_ack arriving during clk_en=0 is still captured: ack is latched, and the FSM moves on the next enabled edge.
- Timeout counter: cleared on entry to ROM_WAIT, saturates at ROM_TIMEOUT.
- Reset mid-ROM_WAIT: rom_req=0 at the next edge, and a late ack is ignored.

## Structure
- huc_bus_pkg holds:
  - the region enum (ROM, WRAM, IO, UNMAPPED) and the state enum;
  - page constants PAGE_WRAM_LO=8'hF8, PAGE_WRAM_HI=8'hFB, PAGE_IO=8'hFF;
  - a decode function from AB_21 to region.
- Sub-module huc_wram_8k: single-port synchronous 8Kx8 RAM with write enable and registered read.

## Test plan
- WRAM: write $5A to $1F0020 and $C3 to $1F0021, then read $1F6020 (mirror) -> DI=$5A one cycle later, RDY_n never high.
- ROM: read $012345 with ack 3 cycles after rom_req -> rom_addr=$12345, RDY_n high 5 cycles, DI=rom_data in DONE.
- ROM, no ack -> bus_err=1 after 255 cycles, DI=$FF, CPU released.
- I/O: write $1FE000=$07 with IO_WAIT=1 -> one io_req pulse with io_we=1, io_addr=0, io_wdata=$07. Then a read -> DI=io_rdata.
- Unmapped read $100000 -> DI=$FF, no stall. Simultaneous RE&WE -> bus_err=1.
- clk_en toggling every other cycle during a ROM wait, then reset asserted while rom_req is high -> rom_req=0 the next cycle, state IDLE, DI=$FF.

Source files
------------

// File: rtl/huc_bus_pkg.sv
// Shared types and address-decode helper for the HuC6280 bus responder.
package huc_bus_pkg;

    typedef enum logic [1:0] {
        RGN_ROM      = 2'd0,
        RGN_WRAM     = 2'd1,
        RGN_IO       = 2'd2,
        RGN_UNMAPPED = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ROM_WAIT = 2'd1,
        S_IO_WAIT  = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    localparam logic [7:0] PAGE_WRAM_LO = 8'hF8;
    localparam logic [7:0] PAGE_WRAM_HI = 8'hFB;
    localparam logic [7:0] PAGE_IO      = 8'hFF;

    // Region of an access, taken from the 8 KB page number AB_21[20:13].
    function automatic region_e decode_region(input logic [7:0] page);
        region_e rgn;
        if (page[7] == 1'b0) begin
            rgn = RGN_ROM;
        end else if ((page >= PAGE_WRAM_LO) && (page <= PAGE_WRAM_HI)) begin
            rgn = RGN_WRAM;
        end else if (page == PAGE_IO) begin
            rgn = RGN_IO;
        end else begin
            rgn = RGN_UNMAPPED;
        end
        return rgn;
    endfunction

endpackage

// File: rtl/huc_wram_8k.sv
// Single-port 8Kx8 synchronous work RAM; the read port register holds between reads.
module huc_wram_8k (
    input  logic        clk,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [12:0] i_addr,
    input  logic [7:0]  i_wdata,
    output logic [7:0]  o_rdata
);

    logic [7:0] r_mem [0:8191];
    logic [7:0] r_q;

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/huc_bus_responder.sv
// Target-side responder for the HuC6280 21-bit bus: serves each access from work RAM,
// a handshaked ROM port or a fixed-latency I/O port, stalling the CPU via RDY_n.
module huc_bus_responder
    import huc_bus_pkg::*;
#(
    parameter int unsigned ROM_TIMEOUT = 255,
    parameter int unsigned IO_WAIT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [20:0] AB_21,
    input  logic        RE,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY_n,
    output logic        rom_req,
    output logic [19:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        io_req,
    output logic        io_we,
    output logic [12:0] io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        bus_err
);

    localparam logic [7:0] ROM_LAST = 8'(ROM_TIMEOUT - 1);
    localparam logic [7:0] ROM_MAX  = 8'(ROM_TIMEOUT);
    localparam logic [3:0] IO_LAST  = 4'(IO_WAIT - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    region_e     w_region;
    logic        w_is_wr;
    logic        w_accept;
    logic        w_rom_rd;
    logic        w_ack;
    logic        w_rom_to;
    logic        w_io_last;
    logic        w_ram_we;
    logic        w_ram_re;
    logic [7:0]  w_ack_data;
    logic [7:0]  w_ram_q;

    logic [7:0]  r_di;
    logic        r_di_sel_ram;
    logic        r_ack_lat;
    logic [7:0]  r_ack_data;
    logic        r_rom_req;
    logic [19:0] r_rom_addr;
    logic [7:0]  r_rom_cnt;
    logic        r_io_req;
    logic        r_io_we;
    logic [12:0] r_io_addr;
    logic [7:0]  r_io_wdata;
    logic [3:0]  r_io_cnt;
    logic        r_bus_err;

    // RE together with WE is handled as a write.
    assign w_region   = decode_region(AB_21[20:13]);
    assign w_is_wr    = WE;
    assign w_accept   = (r_state == S_IDLE) && clk_en && (RE || WE);
    assign w_rom_rd   = (w_region == RGN_ROM) && !w_is_wr;
    assign w_ack      = rom_ack || r_ack_lat;
    assign w_ack_data = rom_ack ? rom_data : r_ack_data;
    assign w_rom_to   = (r_rom_cnt == ROM_LAST);
    assign w_io_last  = (r_io_cnt == IO_LAST);
    assign w_ram_we   = w_accept && (w_region == RGN_WRAM) && w_is_wr;
    assign w_ram_re   = w_accept && (w_region == RGN_WRAM) && !w_is_wr;

    huc_wram_8k u_wram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (AB_21[12:0]),
        .i_wdata (DO),
        .o_rdata (w_ram_q)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and CPU stall; DONE swallows the CPU's held repeat of the access
    always_comb begin
        w_state_nxt = r_state;
        RDY_n       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_rom_rd) begin
                    w_state_nxt = S_ROM_WAIT;
                    RDY_n       = 1'b1;
                end else if (w_accept && (w_region == RGN_IO)) begin
                    w_state_nxt = S_IO_WAIT;
                    RDY_n       = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ROM_WAIT: begin
                RDY_n = 1'b1;
                if (clk_en && (w_ack || w_rom_to)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ROM_WAIT;
                end
            end
            S_IO_WAIT: begin
                RDY_n = 1'b1;
                if (clk_en && w_io_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IO_WAIT;
                end
            end
            S_DONE: begin
                if (clk_en) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: request latches, wait counters, read data and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_di         <= 8'hFF;
            r_di_sel_ram <= 1'b0;
            r_ack_lat    <= 1'b0;
            r_ack_data   <= 8'h00;
            r_rom_req    <= 1'b0;
            r_rom_addr   <= 20'h00000;
            r_rom_cnt    <= 8'h00;
            r_io_req     <= 1'b0;
            r_io_we      <= 1'b0;
            r_io_addr    <= 13'h0000;
            r_io_wdata   <= 8'h00;
            r_io_cnt     <= 4'h0;
            r_bus_err    <= 1'b0;
        end else begin
            r_io_req <= 1'b0;
            if (w_accept) begin
                if (RE && WE) begin
                    r_bus_err <= 1'b1;
                end
                case (w_region)
                    RGN_ROM: begin
                        if (!w_is_wr) begin
                            r_rom_addr <= AB_21[19:0];
                            r_rom_req  <= 1'b1;
                            r_rom_cnt  <= 8'h00;
                            r_ack_lat  <= 1'b0;
                        end
                    end
                    RGN_WRAM: begin
                        if (!w_is_wr) begin
                            r_di_sel_ram <= 1'b1;
                        end
                    end
                    RGN_IO: begin
                        r_io_addr  <= AB_21[12:0];
                        r_io_wdata <= DO;
                        r_io_we    <= w_is_wr;
                        r_io_req   <= 1'b1;
                        r_io_cnt   <= 4'h0;
                    end
                    default: begin
                        if (!w_is_wr) begin
                            r_di         <= 8'hFF;
                            r_di_sel_ram <= 1'b0;
                        end
                    end
                endcase
            end else if (r_state == S_ROM_WAIT) begin
                // An ack seen while the CPU clock is gated is held for the next enabled edge
                if (!clk_en) begin
                    if (rom_ack) begin
                        r_ack_lat  <= 1'b1;
                        r_ack_data <= rom_data;
                    end
                end else if (w_ack) begin
                    r_di         <= w_ack_data;
                    r_di_sel_ram <= 1'b0;
                    r_rom_req    <= 1'b0;
                    r_ack_lat    <= 1'b0;
                end else if (w_rom_to) begin
                    r_di         <= 8'hFF;
                    r_di_sel_ram <= 1'b0;
                    r_rom_req    <= 1'b0;
                    r_bus_err    <= 1'b1;
                end else if (r_rom_cnt != ROM_MAX) begin
                    r_rom_cnt <= r_rom_cnt + 8'd1;
                end
            end else if ((r_state == S_IO_WAIT) && clk_en) begin
                if (w_io_last) begin
                    if (!r_io_we) begin
                        r_di         <= io_rdata;
                        r_di_sel_ram <= 1'b0;
                    end
                end else begin
                    r_io_cnt <= r_io_cnt + 4'd1;
                end
            end
        end
    end

    assign DI       = r_di_sel_ram ? w_ram_q : r_di;
    assign rom_req  = r_rom_req;
    assign rom_addr = r_rom_addr;
    assign io_req   = r_io_req;
    assign io_we    = r_io_we;
    assign io_addr  = r_io_addr;
    assign io_wdata = r_io_wdata;
    assign bus_err  = r_bus_err;

endmodule
